sum_acc: RTL and testbench

SUM_ACC -- requirements
Module: sum_acc

---
 rtl/sum_acc_pkg.sv | 11 +
 rtl/sum_acc_if.sv | 24 ++
 rtl/sum_acc.sv | 86 ++++++++
 tb/tb_sum_acc.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sum_acc_pkg.sv
// Shared types for the sum_acc batch accumulator.
// Holds the FSM state encoding and the width of one adder sample.
package sum_acc_pkg;
    localparam int SAMPLE_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;
endpackage

// File: rtl/sum_acc_if.sv
// Sample-in / total-out handshake bundle for sum_acc.
// The master side is the producer of samples and the consumer of totals.
interface sum_acc_if #(
    parameter int ACC_W = 8
);
    logic             In_valid;
    logic [3:0]       O;
    logic             Carry;
    logic             In_ready;
    logic             Out_valid;
    logic             Out_ready;
    logic [ACC_W-1:0] Total;
    logic             Ovf;

    modport master (
        output In_valid, O, Carry, Out_ready,
        input  In_ready, Out_valid, Total, Ovf
    );

    modport slave (
        input  In_valid, O, Carry, Out_ready,
        output In_ready, Out_valid, Total, Ovf
    );
endinterface

// File: rtl/sum_acc.sv
// Accumulates N_SAMPLES 5-bit adder results {Carry,O} into one batch total.
// Define SUM_ACC_SAT_EN to clamp the total on overflow instead of wrapping.
module sum_acc
    import sum_acc_pkg::*;
#(
    parameter int N_SAMPLES = 4,
    parameter int ACC_W     = 8
) (
    input  logic     clk,
    input  logic     rst_n,
    sum_acc_if.slave bus
);
    localparam int CNT_W = 8;

    state_t           state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] count;
    logic             ovf;
    logic             in_ready;
    logic             out_valid;

    logic [ACC_W:0]   sample;
    logic [ACC_W:0]   sum;
    logic [ACC_W-1:0] next_acc;
    logic             accept;
    logic             last;
    logic             add_ovf;

    // acc is zero in IDLE, so the first accept of a batch is a plain load via the same adder
    always_comb begin
        sample  = (ACC_W+1)'({bus.Carry, bus.O});
        accept  = bus.In_valid && in_ready;
        sum     = {1'b0, acc} + sample;
        add_ovf = sum[ACC_W];
        last    = (count + CNT_W'(1)) == CNT_W'(N_SAMPLES);
`ifdef SUM_ACC_SAT_EN
        next_acc = (add_ovf || ovf) ? '1 : sum[ACC_W-1:0];
`else
        next_acc = sum[ACC_W-1:0];
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc   <= next_acc;
                        count <= count + CNT_W'(1);
                        ovf   <= ovf | add_ovf;
                        if (last) begin
                            state     <= HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    if (bus.Out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        count     <= '0;
                        ovf       <= 1'b0;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.In_ready  = in_ready;
    assign bus.Out_valid = out_valid;
    assign bus.Total     = acc;
    assign bus.Ovf       = ovf;
endmodule

// File: tb/tb_sum_acc.sv
// Directed bench for sum_acc: three instances (N_SAMPLES = 4, 16, 1) driven in turn,
// batch results checked against a scoreboard queue filled as samples are driven.
module tb_sum_acc;
    import sum_acc_pkg::*;

`ifdef SUM_ACC_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sum_acc_if #(.ACC_W(8)) b4 ();
    sum_acc_if #(.ACC_W(8)) b16 ();
    sum_acc_if #(.ACC_W(8)) b1 ();

    sum_acc #(.N_SAMPLES(4),  .ACC_W(8)) u4  (.clk(clk), .rst_n(rst_n), .bus(b4));
    sum_acc #(.N_SAMPLES(16), .ACC_W(8)) u16 (.clk(clk), .rst_n(rst_n), .bus(b16));
    sum_acc #(.N_SAMPLES(1),  .ACC_W(8)) u1  (.clk(clk), .rst_n(rst_n), .bus(b1));

    typedef struct {
        logic [7:0] total;
        logic       ovf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cnt4   = 0;
    int   sum4   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int model_total(input int true_sum);
        if (SAT && true_sum > 255) return 255;
        return true_sum % 256;
    endfunction

    task automatic push(input int true_sum);
        exp_t e;
        e.total = 8'(model_total(true_sum));
        e.ovf   = (true_sum > 255);
        q.push_back(e);
    endtask

    task automatic pop_chk(input string tag, input logic [7:0] t, input logic o);
        exp_t e;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s observed=output expected=scoreboard entry", tag);
        end else begin
            e = q.pop_front();
            chk({tag, "_total"}, 32'(t), 32'(e.total));
            chk({tag, "_ovf"}, 32'(o), 32'(e.ovf));
        end
    endtask

    // Drives one accepted sample into u4 and advances the bench model.
    task automatic send4(input int v);
        b4.In_valid = 1'b1;
        {b4.Carry, b4.O} = 5'(v);
        chk("in_ready4", 32'(b4.In_ready), 1);
        @(negedge clk);
        b4.In_valid = 1'b0;
        cnt4++;
        sum4 += v;
        if (cnt4 == 4) begin
            push(sum4);
            cnt4 = 0;
            sum4 = 0;
        end else begin
            chk("running4", 32'(b4.Total), 32'(sum4));
        end
    endtask

    initial begin
        b4.In_valid = 1'b0;  b4.O = '0;  b4.Carry = 1'b0;  b4.Out_ready = 1'b1;
        b16.In_valid = 1'b0; b16.O = '0; b16.Carry = 1'b0; b16.Out_ready = 1'b1;
        b1.In_valid = 1'b0;  b1.O = '0;  b1.Carry = 1'b0;  b1.Out_ready = 1'b0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst_total", 32'(b4.Total), 0);
        chk("rst_ovf", 32'(b4.Ovf), 0);
        chk("rst_ovalid", 32'(b4.Out_valid), 0);
        chk("rst_iready", 32'(b4.In_ready), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // four samples of 30 with the consumer ready
        for (int i = 0; i < 4; i++) send4(30);
        chk("ovalid_120", 32'(b4.Out_valid), 1);
        chk("iready_hold", 32'(b4.In_ready), 0);
        pop_chk("batch_120", b4.Total, b4.Ovf);
        @(negedge clk);
        chk("idle_ovalid", 32'(b4.Out_valid), 0);
        chk("idle_total", 32'(b4.Total), 0);
        chk("idle_iready", 32'(b4.In_ready), 1);

        // gapped valid: idle cycles carry junk that must not be taken
        send4(3);
        b4.In_valid = 1'b0; {b4.Carry, b4.O} = 5'd17; @(negedge clk);
        chk("gap1_total", 32'(b4.Total), 3);
        send4(9);
        b4.In_valid = 1'b0; {b4.Carry, b4.O} = 5'd17; @(negedge clk);
        chk("gap2_total", 32'(b4.Total), 12);
        send4(5);
        b4.In_valid = 1'b0; {b4.Carry, b4.O} = 5'd17; @(negedge clk);
        chk("gap3_total", 32'(b4.Total), 17);
        send4(7);
        chk("ovalid_24", 32'(b4.Out_valid), 1);
        pop_chk("batch_24", b4.Total, b4.Ovf);
        @(negedge clk);

        // backpressure in HOLD while upstream keeps offering samples
        b4.Out_ready = 1'b0;
        send4(10); send4(20); send4(30); send4(5);
        pop_chk("batch_65", b4.Total, b4.Ovf);
        for (int i = 0; i < 5; i++) begin
            b4.In_valid = 1'b1; {b4.Carry, b4.O} = 5'd30;
            chk("stall_ovalid", 32'(b4.Out_valid), 1);
            chk("stall_iready", 32'(b4.In_ready), 0);
            chk("stall_total", 32'(b4.Total), 65);
            chk("stall_ovf", 32'(b4.Ovf), 0);
            @(negedge clk);
        end
        b4.In_valid = 1'b0;
        b4.Out_ready = 1'b1;
        @(negedge clk);
        chk("release_ovalid", 32'(b4.Out_valid), 0);
        chk("release_total", 32'(b4.Total), 0);
        chk("release_iready", 32'(b4.In_ready), 1);

        // reset mid-batch discards the partial sum
        send4(1); send4(1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_total", 32'(b4.Total), 0);
        chk("midrst_ovalid", 32'(b4.Out_valid), 0);
        chk("midrst_iready", 32'(b4.In_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        cnt4 = 0;
        sum4 = 0;
        for (int i = 0; i < 4; i++) send4(1);
        chk("ovalid_4", 32'(b4.Out_valid), 1);
        pop_chk("batch_4", b4.Total, b4.Ovf);
        @(negedge clk);

        // reset while a result is pending in HOLD
        b4.Out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send4(30);
        pop_chk("batch_pend", b4.Total, b4.Ovf);
        #2 rst_n = 1'b0;
        #1;
        chk("holdrst_ovalid", 32'(b4.Out_valid), 0);
        chk("holdrst_total", 32'(b4.Total), 0);
        @(negedge clk);
        rst_n = 1'b1;
        b4.Out_ready = 1'b1;
        @(negedge clk);

        // sixteen samples of 30 overflow an 8-bit accumulator at the ninth
        for (int i = 1; i <= 16; i++) begin
            b16.In_valid = 1'b1; {b16.Carry, b16.O} = 5'd30;
            @(negedge clk);
            b16.In_valid = 1'b0;
            if (i == 8) chk("ovf16_at8", 32'(b16.Ovf), 0);
            if (i == 9) begin
                chk("ovf16_at9", 32'(b16.Ovf), 1);
                chk("total16_at9", 32'(b16.Total), 32'(model_total(270)));
            end
        end
        push(480);
        chk("ovalid16", 32'(b16.Out_valid), 1);
        pop_chk("batch16", b16.Total, b16.Ovf);
        @(negedge clk);
        chk("idle16_total", 32'(b16.Total), 0);
        chk("idle16_ovf", 32'(b16.Ovf), 0);

        // single-sample batch of value 0
        b1.In_valid = 1'b1; {b1.Carry, b1.O} = 5'd0;
        push(0);
        @(negedge clk);
        b1.In_valid = 1'b0;
        chk("ovalid1", 32'(b1.Out_valid), 1);
        chk("iready1", 32'(b1.In_ready), 0);
        pop_chk("batch1", b1.Total, b1.Ovf);
        b1.Out_ready = 1'b1;
        @(negedge clk);
        chk("idle1_ovalid", 32'(b1.Out_valid), 0);
        chk("idle1_iready", 32'(b1.In_ready), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
